sprite_fetch: RTL

Per-scanline sprite row fetcher that feeds the sprite line renderers. It runs once per line at `line_start` and scans the sprite attribute table. For each sprite it decides whether the sprite covers the next scanline, reads that sprite's 16-pixel, 2-bpp pattern row from pattern memory, and writes `colors`/`posX`/`swpX` into the renderer bank's per-sprite holding registers. Missed or disabled sprites are written with all-zero colors, so no stale row remains on screen.

---
 rtl/sprite_fetch_if.sv | 22 ++
 rtl/sprite_fetch.sv | 91 +++++++++
 2 files changed

// File: rtl/sprite_fetch_if.sv
// sprite_fetch_if: attribute/pattern memory reads and renderer-bank write bus
interface sprite_fetch_if #(
   parameter int IW = 3
);
   logic [IW-1:0] attr_addr;
   logic [31:0]   attr_data;
   logic [11:0]   pat_addr;
   logic [31:0]   pat_data;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [31:0]   wr_colors;
   logic [8:0]    wr_posX;
   logic          wr_swpX;
   modport master (
      output attr_addr, pat_addr, wr_en, wr_idx, wr_colors, wr_posX, wr_swpX,
      input  attr_data, pat_data
   );
   modport slave (
      input  attr_addr, pat_addr, wr_en, wr_idx, wr_colors, wr_posX, wr_swpX,
      output attr_data, pat_data
   );
endinterface

// File: rtl/sprite_fetch.sv
// sprite_fetch: per-scanline sprite attribute scan and pattern row fetch
module sprite_fetch #(
   parameter int NSPR = 8,
   parameter int IW   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  line_start,
   input  logic [9:0]            CounterY,
   sprite_fetch_if.master        bus,
   output logic                  busy,
   output logic                  done
);
   typedef enum logic [2:0] {IDLE, AREQ, ADAT, PREQ, PDAT} state_t;
   state_t        state;
   logic [8:0]    ly;
   logic [8:0]    pos_x;
   logic          swp_x;
   logic [IW-1:0] idx;
   logic [8:0]    rely;
   logic          hit;
   logic [3:0]    row;
   logic          last;
   assign rely = ly - bus.attr_data[28:20];
   assign hit  = bus.attr_data[31] & ~|rely[8:4];
   assign row  = bus.attr_data[30] ? 4'd15 - rely[3:0] : rely[3:0];
   assign last = idx == IW'(NSPR - 1);
   // busy also covers the done cycle so it spans the whole scan including the final write
   assign busy = (state != IDLE) | done;
   // scan FSM: one attribute read per sprite, one pattern read per hit, one write per slot
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         ly            <= '0;
         pos_x         <= '0;
         swp_x         <= 1'b0;
         bus.attr_addr <= '0;
         bus.pat_addr  <= '0;
         bus.wr_en     <= 1'b0;
         bus.wr_idx    <= '0;
         bus.wr_colors <= '0;
         bus.wr_posX   <= '0;
         bus.wr_swpX   <= 1'b0;
         done          <= 1'b0;
      end else begin
         bus.wr_en <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: if (line_start) begin
               ly            <= CounterY[9:1];
               idx           <= '0;
               bus.attr_addr <= '0;
               state         <= AREQ;
            end
            AREQ: state <= ADAT;
            ADAT: begin
               pos_x <= bus.attr_data[19:11];
               swp_x <= bus.attr_data[29];
               if (hit) begin
                  bus.pat_addr <= {bus.attr_data[10:3], row};
                  state        <= PREQ;
               end else begin
                  bus.wr_en     <= 1'b1;
                  bus.wr_idx    <= idx;
                  bus.wr_colors <= '0;
                  bus.wr_posX   <= bus.attr_data[19:11];
                  bus.wr_swpX   <= bus.attr_data[29];
                  done          <= last;
                  idx           <= last ? idx : idx + IW'(1);
                  bus.attr_addr <= last ? bus.attr_addr : idx + IW'(1);
                  state         <= last ? IDLE : AREQ;
               end
            end
            PREQ: state <= PDAT;
            PDAT: begin
               bus.wr_en     <= 1'b1;
               bus.wr_idx    <= idx;
               bus.wr_colors <= bus.pat_data;
               bus.wr_posX   <= pos_x;
               bus.wr_swpX   <= swp_x;
               done          <= last;
               idx           <= last ? idx : idx + IW'(1);
               bus.attr_addr <= last ? bus.attr_addr : idx + IW'(1);
               state         <= last ? IDLE : AREQ;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
